// File: rtl/nonce_collector_pkg.sv
// Shared miner definitions used by the nonce collector: the block-tracking
// state enum, default sizing constants and a saturating counter helper.
package nonce_collector_pkg;

  typedef enum logic {
    WAIT   = 1'b0,
    ACTIVE = 1'b1
  } collector_state_t;

  localparam int DEFAULT_NONCEBITS = 32;
  localparam int DEFAULT_LOGDEPTH  = 2;

  // Increment that sticks at all-ones instead of wrapping back to zero.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/nonce_fifo.sv
// Synchronous FIFO with a single-cycle flush and a registered head output.
// A flush empties the queue but still accepts a push in the same cycle, so
// the entry written alongside a flush becomes the only entry.
module nonce_fifo #(
  parameter int LOGDEPTH = 2,
  parameter int WIDTH    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                push,
  input  logic                pop,
  input  logic [WIDTH-1:0]    din,
  output logic [WIDTH-1:0]    dout,
  output logic                valid,
  output logic [LOGDEPTH:0]   level,
  output logic                dropped
);

  localparam int DEPTH = 1 << LOGDEPTH;
  localparam int CW    = LOGDEPTH + 1;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [LOGDEPTH-1:0] rd_ptr;
  logic [LOGDEPTH-1:0] wr_ptr;
  logic [LOGDEPTH-1:0] wr_addr;
  logic [LOGDEPTH-1:0] rd_next;
  logic [CW-1:0]       count;
  logic [CW-1:0]       count_next;
  logic                full;
  logic                pop_ok;
  logic                push_ok;
  logic [WIDTH-1:0]    head_next;

  // Decide which pushes/pops take effect and what the head will be next cycle;
  // a full queue still takes a push when a pop frees a slot in the same cycle.
  always_comb begin
    full     = (count == CW'(DEPTH));
    pop_ok   = pop & (count != '0) & ~flush;
    push_ok  = push & (flush | ~full | pop_ok);
    dropped  = push & ~push_ok;
    wr_addr  = flush ? '0 : wr_ptr;
    rd_next  = rd_ptr + LOGDEPTH'(1);

    if (flush) begin
      count_next = CW'(push);
    end else begin
      count_next = count + CW'(push_ok) - CW'(pop_ok);
    end

    head_next = dout;
    if (count_next == '0) begin
      head_next = '0;
    end else if (flush) begin
      head_next = din;
    end else if (pop_ok) begin
      head_next = (count == CW'(1)) ? din : mem[rd_next];
    end else if (count == '0) begin
      head_next = din;
    end
  end

  // Storage array needs no reset; occupancy tracking decides what is live.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_addr] <= din;
    end
  end

  // Pointer, occupancy and registered head bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      count <= count_next;
      dout  <= head_next;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= LOGDEPTH'(push);
      end else begin
        if (push_ok) begin
          wr_ptr <= wr_ptr + LOGDEPTH'(1);
        end
        if (pop_ok) begin
          rd_ptr <= rd_next;
        end
      end
    end
  end

  assign valid = (count != '0);
  assign level = count;

endmodule

// File: rtl/nonce_collector.sv
// Collects successful miner nonces into a small FIFO. Each valid hash result
// is numbered by a per-block counter: the first result of a new block is nonce
// 0 and later results count up from there. Results seen before the first new
// block are ignored. A new block also flushes stale nonces and clears the
// sticky overflow flag.
// Optional feature macro: NONCE_COLLECTOR_STATS_EN adds the hitCount output.
module nonce_collector
  import nonce_collector_pkg::*;
#(
  parameter int LOGDEPTH  = DEFAULT_LOGDEPTH,
  parameter int NONCEBITS = DEFAULT_NONCEBITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 validIn,
  input  logic                 newBlockIn,
  input  logic                 successIn,
  input  logic                 rdEn,
  output logic [NONCEBITS-1:0] nonceOut,
  output logic                 nonceValid,
  output logic                 overflow,
  output logic [LOGDEPTH:0]    level
`ifdef NONCE_COLLECTOR_STATS_EN
  ,
  output logic [31:0]          hitCount
`endif
);

  collector_state_t     state;
  logic [NONCEBITS-1:0] nonce_ctr;
  logic [NONCEBITS-1:0] assigned_nonce;
  logic                 new_block;
  logic                 accepted;
  logic                 push_req;
  logic                 dropped;

  // Number the current result; a new block both restarts numbering and
  // activates collection in the very same cycle.
  always_comb begin
    new_block      = validIn & newBlockIn;
    accepted       = validIn & (newBlockIn | (state == ACTIVE));
    assigned_nonce = newBlockIn ? '0 : nonce_ctr + NONCEBITS'(1);
    push_req       = accepted & successIn;
  end

  // Block-tracking state and last assigned nonce; the counter wraps silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT;
      nonce_ctr <= '0;
    end else if (accepted) begin
      state     <= ACTIVE;
      nonce_ctr <= assigned_nonce;
    end
  end

  // Sticky overflow: set when a success is lost, cleared by a new block.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (new_block) begin
      overflow <= 1'b0;
    end else if (dropped) begin
      overflow <= 1'b1;
    end
  end

  nonce_fifo #(
    .LOGDEPTH (LOGDEPTH),
    .WIDTH    (NONCEBITS)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (new_block),
    .push    (push_req),
    .pop     (rdEn),
    .din     (assigned_nonce),
    .dout    (nonceOut),
    .valid   (nonceValid),
    .level   (level),
    .dropped (dropped)
  );

`ifdef NONCE_COLLECTOR_STATS_EN
  // Count every accepted success, including ones the full FIFO had to drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      hitCount <= '0;
    end else if (push_req) begin
      hitCount <= sat_inc32(hitCount);
    end
  end
`endif

endmodule

// File: tb/tb_nonce_collector.sv
// Testbench for nonce_collector: a table of directed vectors, hand-written
// wrap/reset sequences on a narrow-counter instance, and a randomized run
// compared every cycle against a queue-based reference model.
// Define NONCE_COLLECTOR_STATS_EN to also check hitCount.
module tb_nonce_collector;

  logic        clk;
  logic        rst;
  logic        validIn;
  logic        newBlockIn;
  logic        successIn;
  logic        rdEn;

  logic [31:0] nonce_out;
  logic        nonce_valid;
  logic        ovf;
  logic [2:0]  lvl;

  logic [3:0]  nonce_out_w;
  logic        nonce_valid_w;
  logic        ovf_w;
  logic [2:0]  lvl_w;

`ifdef NONCE_COLLECTOR_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] hit_count_w;
`endif

  int pass_count  = 0;
  int check_count = 0;

  // Reference model: what the collector should hold, kept as a plain queue.
  logic [31:0] model_q[$];
  bit          m_active;
  logic [31:0] m_last;
  bit          m_ovf;
  logic [31:0] m_hits;

  typedef struct {
    logic        v;
    logic        n;
    logic        s;
    logic        r;
    logic        ev;
    logic [2:0]  el;
    logic [31:0] en;
    logic        eo;
  } vec_t;

  vec_t tbl[$];

  // Default-width collector, the main device under test.
  nonce_collector dut (
    .clk        (clk),
    .rst        (rst),
    .validIn    (validIn),
    .newBlockIn (newBlockIn),
    .successIn  (successIn),
    .rdEn       (rdEn),
    .nonceOut   (nonce_out),
    .nonceValid (nonce_valid),
    .overflow   (ovf),
    .level      (lvl)
`ifdef NONCE_COLLECTOR_STATS_EN
    ,
    .hitCount   (hit_count)
`endif
  );

  // Narrow-counter instance so counter wrap-around is reachable quickly.
  nonce_collector #(.LOGDEPTH(2), .NONCEBITS(4)) dut_w (
    .clk        (clk),
    .rst        (rst),
    .validIn    (validIn),
    .newBlockIn (newBlockIn),
    .successIn  (successIn),
    .rdEn       (rdEn),
    .nonceOut   (nonce_out_w),
    .nonceValid (nonce_valid_w),
    .overflow   (ovf_w),
    .level      (lvl_w)
`ifdef NONCE_COLLECTOR_STATS_EN
    ,
    .hitCount   (hit_count_w)
`endif
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(logic v, logic n, logic s, logic r,
                              logic ev, int el, int en, logic eo);
    vec_t t;
    t.v = v; t.n = n; t.s = s; t.r = r;
    t.ev = ev; t.el = 3'(el); t.en = 32'(en); t.eo = eo;
    return t;
  endfunction

  // Advance the reference model by one clock using the current inputs.
  task automatic modelStep();
    bit   do_pop;
    bit   take;
    logic [31:0] nonce;
    if (rst) begin
      model_q.delete();
      m_active = 0;
      m_last   = '0;
      m_ovf    = 0;
      m_hits   = '0;
      return;
    end
    do_pop = rdEn && (model_q.size() > 0);
    take   = 0;
    nonce  = '0;
    if (validIn) begin
      if (newBlockIn) begin
        model_q.delete();
        m_active = 1;
        m_ovf    = 0;
        do_pop   = 0;
        nonce    = '0;
        take     = 1;
      end else if (m_active) begin
        nonce = m_last + 32'd1;
        take  = 1;
      end
      if (take) m_last = nonce;
    end
    if (do_pop) void'(model_q.pop_front());
    if (take && successIn) begin
      if (m_hits != 32'hFFFF_FFFF) m_hits = m_hits + 32'd1;
      if (model_q.size() < 4) model_q.push_back(nonce);
      else m_ovf = 1;
    end
  endtask

  task automatic applyStimulus(input logic v, input logic n, input logic s, input logic r);
    validIn    = v;
    newBlockIn = n;
    successIn  = s;
    rdEn       = r;
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic resetDut();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0);
    rst = 1'b0;
  endtask

  // Main sequence: directed table, wrap/reset corners, then random run.
  initial begin
    rst = 1'b1; validIn = 0; newBlockIn = 0; successIn = 0; rdEn = 0;

    // Fields: v n s r | valid level head overflow (state after the edge)
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1,0,1,0, 0,0,0,0));
    tbl.push_back(mk(1,1,0,0, 0,0,0,0));
    tbl.push_back(mk(1,0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,0,1,0, 1,1,3,0));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1,0,0,0, 1,1,3,0));
    tbl.push_back(mk(1,0,1,0, 1,2,3,0));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(1,0,0,0, 1,2,3,0));
    tbl.push_back(mk(0,0,0,1, 1,1,7,0));
    tbl.push_back(mk(0,0,0,1, 0,0,0,0));
    tbl.push_back(mk(0,0,0,1, 0,0,0,0));
    tbl.push_back(mk(1,0,1,0, 1,1,11,0));
    tbl.push_back(mk(1,0,1,0, 1,2,11,0));
    tbl.push_back(mk(1,0,1,0, 1,3,11,0));
    tbl.push_back(mk(1,0,1,0, 1,4,11,0));
    tbl.push_back(mk(1,0,1,0, 1,4,11,1));
    tbl.push_back(mk(0,0,0,0, 1,4,11,1));
    tbl.push_back(mk(0,0,0,1, 1,3,12,1));
    tbl.push_back(mk(0,0,0,1, 1,2,13,1));
    tbl.push_back(mk(1,1,1,0, 1,1,0,0));
    tbl.push_back(mk(1,0,1,0, 1,2,0,0));
    tbl.push_back(mk(1,0,1,0, 1,3,0,0));
    tbl.push_back(mk(1,0,1,0, 1,4,0,0));
    tbl.push_back(mk(1,0,1,1, 1,4,1,0));
    tbl.push_back(mk(0,0,0,1, 1,3,2,0));
    tbl.push_back(mk(0,0,0,1, 1,2,3,0));
    tbl.push_back(mk(0,0,0,1, 1,1,4,0));
    tbl.push_back(mk(0,0,0,1, 0,0,0,0));

    resetDut();
    checkOutput("reset_valid", 32'(nonce_valid), 32'd0);
    checkOutput("reset_level", 32'(lvl), 32'd0);
    checkOutput("reset_nonce", nonce_out, 32'd0);
    checkOutput("reset_overflow", 32'(ovf), 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].v, tbl[i].n, tbl[i].s, tbl[i].r);
      checkOutput($sformatf("vec%0d_valid", i), 32'(nonce_valid), 32'(tbl[i].ev));
      checkOutput($sformatf("vec%0d_level", i), 32'(lvl), 32'(tbl[i].el));
      checkOutput($sformatf("vec%0d_overflow", i), 32'(ovf), 32'(tbl[i].eo));
      if (tbl[i].ev) checkOutput($sformatf("vec%0d_nonce", i), nonce_out, tbl[i].en);
    end

    // Counter wrap on the 4-bit instance: nonces 14, 15 then 0.
    resetDut();
    applyStimulus(1, 1, 0, 0);
    repeat (13) applyStimulus(1, 0, 0, 0);
    repeat (3) applyStimulus(1, 0, 1, 0);
    checkOutput("wrap_level", 32'(lvl_w), 32'd3);
    checkOutput("wrap_head0", 32'(nonce_out_w), 32'd14);
    checkOutput("wrap_overflow", 32'(ovf_w), 32'd0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("wrap_head1", 32'(nonce_out_w), 32'd15);
    applyStimulus(0, 0, 0, 1);
    checkOutput("wrap_head2", 32'(nonce_out_w), 32'd0);
    checkOutput("wide_nowrap_head", nonce_out, 32'd16);
    checkOutput("wide_nowrap_level", 32'(lvl), 32'd1);

    // Reset in mid-stream wins over a simultaneous push and pop.
    rst = 1'b1;
    applyStimulus(1, 0, 1, 1);
    rst = 1'b0;
    checkOutput("midrst_valid", 32'(nonce_valid), 32'd0);
    checkOutput("midrst_level", 32'(lvl), 32'd0);
    checkOutput("midrst_nonce", nonce_out, 32'd0);
    checkOutput("midrst_overflow", 32'(ovf), 32'd0);
    checkOutput("midrst_w_valid", 32'(nonce_valid_w), 32'd0);
    checkOutput("midrst_w_nonce", 32'(nonce_out_w), 32'd0);
    applyStimulus(1, 0, 1, 0);
    checkOutput("postrst_wait_level", 32'(lvl), 32'd0);

    // Randomized run against the reference model.
    resetDut();
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      applyStimulus($urandom_range(0, 9) < 7,
                    $urandom_range(0, 24) == 0,
                    $urandom_range(0, 9) < 4,
                    $urandom_range(0, 9) < ((i < 400) ? 2 : 5));
      rst = 1'b0;
      checkOutput("rnd_valid", 32'(nonce_valid), 32'(model_q.size() > 0));
      checkOutput("rnd_level", 32'(lvl), 32'(model_q.size()));
      checkOutput("rnd_overflow", 32'(ovf), 32'(m_ovf));
      if (model_q.size() > 0) checkOutput("rnd_nonce", nonce_out, model_q[0]);
`ifdef NONCE_COLLECTOR_STATS_EN
      checkOutput("rnd_hits", hit_count, m_hits);
`endif
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
